// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues ALU commands, sequences the ALU handshake and holds responses; define ALU_CMD_DRIVER_STATS_EN for op/timeout counters
module alu_cmd_driver #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_W-1:0]     cmd_a,
  input  logic [DATA_W-1:0]     cmd_b,
  input  logic [2:0]            cmd_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_op,
  output logic                  alu_start,
  output logic                  alu_reset_n,
  input  logic                  alu_done,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_result,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [15:0]           op_count,
  output logic [15:0]           timeout_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, WAIT, NOP, ARST, RESP} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem_a [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_b [FIFO_DEPTH];
  logic [2:0] mem_op [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [TW-1:0] timer;
  logic push, pop, done_ev, to_ev;
  logic [2:0] head_op;
  assign cmd_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state == IDLE && count != '0;
  assign head_op   = mem_op[rd_ptr];
  assign done_ev   = state == WAIT && alu_done;
  assign to_ev     = state == WAIT && !alu_done && timer == TW'(TIMEOUT - 1);
  assign busy      = state != IDLE || count != '0;
  // command storage is write-only from the port side, so it carries no reset
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wr_ptr]  <= cmd_a;
      mem_b[wr_ptr]  <= cmd_b;
      mem_op[wr_ptr] <= cmd_op;
    end
  // FIFO pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  // dispatch by opcode from IDLE; leave WAIT on done or expiry, ARST after its second cycle
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pop) state_d = head_op == 3'b111 ? ARST : (head_op inside {[3'b001:3'b100]}) ? WAIT : NOP;
      WAIT:    if (done_ev || to_ev) state_d = RESP;
      NOP:     state_d = IDLE;
      ARST:    if (timer == TW'(1)) state_d = IDLE;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // ALU drive follows the next state; timer restarts on every state change
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_start   <= 1'b0;
      alu_reset_n <= 1'b0;
      timer       <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      alu_start   <= state_d == WAIT || state_d == NOP;
      alu_reset_n <= state_d != ARST;
      timer       <= state_d == state ? timer + TW'(1) : '0;
      if (pop) begin
        alu_a  <= mem_a[rd_ptr];
        alu_b  <= mem_b[rd_ptr];
        alu_op <= head_op;
      end
      if (done_ev || to_ev) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= done_ev ? alu_result : '0;
        rsp_timeout <= to_ev;
      end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
`ifdef ALU_CMD_DRIVER_STATS_EN
  // saturating counts of normal and timed-out responses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_count      <= '0;
      timeout_count <= '0;
    end else begin
      if (done_ev && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (to_ev && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
    end
`else
  assign op_count      = '0;
  assign timeout_count = '0;
`endif
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed self-checking bench for alu_cmd_driver
module tb_alu_cmd_driver;
  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, alu_start, alu_reset_n, alu_done, rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b;
  logic [2:0] cmd_op, alu_op;
  logic [15:0] alu_result, rsp_result, op_count, timeout_count;
  int n_cmp = 0, n_err = 0, n_ops = 0, n_tos = 0;
  bit flag;
`ifdef ALU_CMD_DRIVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  always #5 clk = ~clk;
  alu_cmd_driver dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start), .alu_reset_n(alu_reset_n),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .busy(busy), .op_count(op_count), .timeout_count(timeout_count)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; alu_done = 0; alu_result = 0; rsp_ready = 0;
    step(); step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL reset_alu_start: got %b want 0", alu_start); end
    n_cmp++; if (alu_reset_n !== 1'b0) begin n_err++; $display("FAIL reset_alu_reset_n: got %b want 0", alu_reset_n); end
    n_cmp++; if ({alu_op, alu_a, alu_b} !== 19'h0) begin n_err++; $display("FAIL reset_alu_regs: got %h want 0", {alu_op, alu_a, alu_b}); end
    n_cmp++; if ({rsp_valid, rsp_timeout, rsp_result} !== 18'h0) begin n_err++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_timeout, rsp_result}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({op_count, timeout_count} !== 32'h0) begin n_err++; $display("FAIL reset_counters: got %h want 0", {op_count, timeout_count}); end
    reset = 1'b0;
    step();
    n_cmp++; if (alu_reset_n !== 1'b1) begin n_err++; $display("FAIL release_alu_reset_n: got %b want 1", alu_reset_n); end
  endtask
  task automatic test_add();
    send(3'b001, 8'hFF, 8'h01);
    n_cmp++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL add_start_early: got %b want 0", alu_start); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b want 1", busy); end
    step();
    n_cmp++; if (alu_start !== 1'b1) begin n_err++; $display("FAIL add_start: got %b want 1", alu_start); end
    n_cmp++; if ({alu_op, alu_a, alu_b} !== {3'b001, 8'hFF, 8'h01}) begin n_err++; $display("FAIL add_operands: got %h want %h", {alu_op, alu_a, alu_b}, {3'b001, 8'hFF, 8'h01}); end
    alu_done = 1'b1; alu_result = 16'h0100;
    step();
    alu_done = 1'b0; n_ops++;
    n_cmp++; if ({rsp_valid, rsp_timeout, rsp_result} !== {2'b10, 16'h0100}) begin n_err++; $display("FAIL add_rsp: got v%b t%b %h want v1 t0 0100", rsp_valid, rsp_timeout, rsp_result); end
    n_cmp++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL add_start_clear: got %b want 0", alu_start); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_rsp_clear: got %b want 0", rsp_valid); end
    n_cmp++; if (op_count !== (STATS ? 16'(n_ops) : 16'h0)) begin n_err++; $display("FAIL add_op_count: got %0d want %0d", op_count, STATS ? n_ops : 0); end
  endtask
  task automatic test_mul_hold();
    send(3'b100, 8'hFF, 8'hFF);
    step();
    alu_done = 1'b1; alu_result = 16'hFE01;
    step();
    alu_done = 1'b0; n_ops++;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin alu_done = 1'b1; alu_result = 16'h1234; end
      step();
      alu_done = 1'b0;
      if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_result !== 16'hFE01) flag = 1'b1;
    end
    n_cmp++; if (flag) begin n_err++; $display("FAIL mul_hold: got v%b t%b %h want v1 t0 fe01 held 5 cycles", rsp_valid, rsp_timeout, rsp_result); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mul_rsp_clear: got %b want 0", rsp_valid); end
    n_cmp++; if (op_count !== (STATS ? 16'(n_ops) : 16'h0)) begin n_err++; $display("FAIL mul_op_count: got %0d want %0d", op_count, STATS ? n_ops : 0); end
  endtask
  task automatic test_back_to_back();
    send(3'b001, 8'h01, 8'h00);
    step();
    cmd_valid = 1'b1; cmd_op = 3'b001;
    for (int i = 1; i <= 4; i++) begin
      cmd_a = 8'(8'h10 + i); cmd_b = 8'(i);
      step();
    end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", cmd_ready); end
    cmd_a = 8'h15; cmd_b = 8'h05;
    step(); step();
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_still_full: got %b want 0", cmd_ready); end
    alu_done = 1'b1; alu_result = 16'h0001;
    step();
    alu_done = 1'b0; n_ops++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_before_pop: got %b want 0", cmd_ready); end
    step();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_pop: got %b want 1", cmd_ready); end
    n_cmp++; if (alu_a !== 8'h11) begin n_err++; $display("FAIL b2b_first_pop: got %h want 11", alu_a); end
    step();
    cmd_valid = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_fifth_taken: got %b want 0", cmd_ready); end
    for (int i = 1; i <= 5; i++) begin
      alu_done = 1'b1; alu_result = 16'(16'h0100 + i);
      step();
      alu_done = 1'b0; n_ops++;
      n_cmp++; if (rsp_result !== 16'(16'h0100 + i)) begin n_err++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rsp_result, 16'(16'h0100 + i)); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      if (i < 5) begin
        step();
        n_cmp++; if (alu_a !== 8'(8'h11 + i)) begin n_err++; $display("FAIL b2b_order%0d: got %h want %h", i, alu_a, 8'(8'h11 + i)); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", busy); end
  endtask
  task automatic test_timeout();
    send(3'b001, 8'h22, 8'h33);
    step();
    repeat (15) step();
    n_cmp++; if ({rsp_valid, alu_start} !== 2'b01) begin n_err++; $display("FAIL to_early: got v%b start%b want v0 start1", rsp_valid, alu_start); end
    step();
    n_tos++;
    n_cmp++; if ({rsp_valid, rsp_timeout, rsp_result} !== {2'b11, 16'h0}) begin n_err++; $display("FAIL to_rsp: got v%b t%b %h want v1 t1 0000", rsp_valid, rsp_timeout, rsp_result); end
    n_cmp++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL to_start_clear: got %b want 0", alu_start); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++; if (timeout_count !== (STATS ? 16'(n_tos) : 16'h0)) begin n_err++; $display("FAIL to_count: got %0d want %0d", timeout_count, STATS ? n_tos : 0); end
  endtask
  task automatic test_done_at_expiry();
    send(3'b011, 8'h0F, 8'hF0);
    step();
    repeat (15) step();
    alu_done = 1'b1; alu_result = 16'h00AB;
    step();
    alu_done = 1'b0; n_ops++;
    n_cmp++; if ({rsp_valid, rsp_timeout, rsp_result} !== {2'b10, 16'h00AB}) begin n_err++; $display("FAIL expiry_done_wins: got v%b t%b %h want v1 t0 00ab", rsp_valid, rsp_timeout, rsp_result); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_cmp++; if ({op_count, timeout_count} !== (STATS ? {16'(n_ops), 16'(n_tos)} : 32'h0)) begin n_err++; $display("FAIL expiry_counts: got %0d/%0d want %0d/%0d", op_count, timeout_count, STATS ? n_ops : 0, STATS ? n_tos : 0); end
  endtask
  task automatic test_rst_op();
    flag = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'b111; cmd_a = 8'hAA; cmd_b = 8'h55;
    step();
    cmd_op = 3'b000; cmd_a = 8'h5A;
    step();
    cmd_valid = 1'b0; flag |= rsp_valid;
    n_cmp++; if ({alu_reset_n, alu_start, alu_op} !== 5'b00111) begin n_err++; $display("FAIL rstop_enter: got n%b s%b op%b want n0 s0 op111", alu_reset_n, alu_start, alu_op); end
    step(); flag |= rsp_valid;
    n_cmp++; if (alu_reset_n !== 1'b0) begin n_err++; $display("FAIL rstop_second: got %b want 0", alu_reset_n); end
    step(); flag |= rsp_valid;
    n_cmp++; if ({alu_reset_n, alu_start} !== 2'b10) begin n_err++; $display("FAIL rstop_exit: got n%b s%b want n1 s0", alu_reset_n, alu_start); end
    step(); flag |= rsp_valid;
    n_cmp++; if ({alu_start, alu_op, alu_a} !== {1'b1, 3'b000, 8'h5A}) begin n_err++; $display("FAIL nop_start: got s%b op%b a%h want s1 op000 a5a", alu_start, alu_op, alu_a); end
    step(); flag |= rsp_valid;
    n_cmp++; if ({alu_start, busy} !== 2'b00) begin n_err++; $display("FAIL nop_end: got s%b busy%b want s0 busy0", alu_start, busy); end
    n_cmp++; if (flag) begin n_err++; $display("FAIL rstop_no_rsp: got rsp_valid 1 want 0"); end
  endtask
  task automatic test_mid_reset();
    send(3'b001, 8'h31, 8'h01);
    step();
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 8'h41;
    step();
    cmd_a = 8'h42;
    step();
    cmd_valid = 1'b0;
    n_cmp++; if ({alu_start, busy} !== 2'b11) begin n_err++; $display("FAIL midrst_pre: got s%b busy%b want s1 busy1", alu_start, busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({alu_start, cmd_ready, busy, alu_reset_n} !== 4'b0100) begin n_err++; $display("FAIL midrst_async: got s%b r%b busy%b n%b want s0 r1 busy0 n0", alu_start, cmd_ready, busy, alu_reset_n); end
    step();
    reset = 1'b0;
    flag = 1'b0; alu_done = 1'b1; alu_result = 16'hBEEF;
    repeat (6) begin
      step();
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_start !== 1'b0) flag = 1'b1;
    end
    alu_done = 1'b0;
    n_cmp++; if (flag) begin n_err++; $display("FAIL midrst_quiet: got v%b busy%b s%b want all 0", rsp_valid, busy, alu_start); end
    n_cmp++; if ({op_count, timeout_count} !== 32'h0) begin n_err++; $display("FAIL midrst_counters: got %h want 0", {op_count, timeout_count}); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_add();
    test_mul_hold();
    test_back_to_back();
    test_timeout();
    test_done_at_expiry();
    test_rst_op();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
